// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// -----------------------------------------------------------------------------
// unsigned_mul_8x8_ha_array_reducer
//
// Consumer end of the unsigned 8x8 ha_array partial-product interface. Four
// half-adder row pairs (carry vector b, sum vector t) from an exact or
// approximate multiplier front end are decoded with their bit weights, reduced
// to a 16-bit product over two valid/ready pipeline stages and registered.
//
// Parameters
//   SAT    1: saturate product to 16'hFFFF when the raw sum overflows 16 bits,
//          0: wrap modulo 2^16
//   ACC_W  accumulator width (only with HA_REDUCE_ACC_EN)
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   row handshake; in_ready is combinational
//   ha_array_k_b  [6:0]   carry vector of row k (k = 0..3)
//   ha_array_k_t  [8:0]   sum vector of row k (k = 0..3)
//   out_valid / out_ready product handshake
//   product      [15:0]   reduced product (registered)
//   ovf                   raw sum exceeded 16 bits (registered)
//   acc_clr               [HA_REDUCE_ACC_EN] synchronous accumulator clear
//   acc_out   [ACC_W-1:0] [HA_REDUCE_ACC_EN] running sum of delivered products
//
// Optional feature macro: HA_REDUCE_ACC_EN (adds acc_clr / acc_out and the
// delivered-product accumulator). Undefined by default.
// -----------------------------------------------------------------------------
module unsigned_mul_8x8_ha_array_reducer #(
    parameter bit SAT = 1'b1
`ifdef HA_REDUCE_ACC_EN
    ,
    parameter int unsigned ACC_W = 32
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  ha_array_0_b,
    input  logic [8:0]  ha_array_0_t,
    input  logic [6:0]  ha_array_1_b,
    input  logic [8:0]  ha_array_1_t,
    input  logic [6:0]  ha_array_2_b,
    input  logic [8:0]  ha_array_2_t,
    input  logic [6:0]  ha_array_3_b,
    input  logic [8:0]  ha_array_3_t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        ovf
`ifdef HA_REDUCE_ACC_EN
    ,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc_out
`endif
);

    localparam int unsigned B_W    = 7;
    localparam int unsigned T_W    = 9;
    localparam int unsigned ROW_W  = 10;
    localparam int unsigned S1_W   = 13;
    localparam int unsigned RAW_W  = 17;
    localparam int unsigned PROD_W = 16;
    localparam int unsigned ROWS   = 4;

    typedef struct packed {
        logic [B_W-1:0] b;
        logic [T_W-1:0] t;
    } ha_row_t;

    // Row value: t at weight 2^j, b[5:0] at 2^(i+2), b[6] at 2^8 (max 1019).
    function automatic logic [ROW_W-1:0] row_decode(input ha_row_t row);
        return ROW_W'(row.t)
             + ROW_W'({row.b[5:0], 2'b00})
             + ROW_W'({row.b[6], 8'h00});
    endfunction

    ha_row_t [ROWS-1:0]  rows;
    logic [ROW_W-1:0]    row_val [ROWS];

    logic                s1_v;
    logic [S1_W-1:0]     s01;
    logic [S1_W-1:0]     s23;

    logic                in_hs;
    logic                s2_load;
    logic                s1_v_d;
    logic                s2_v_d;
    logic [S1_W-1:0]     s01_d;
    logic [S1_W-1:0]     s23_d;
    logic [RAW_W-1:0]    raw_c;
    logic [PROD_W-1:0]   product_d;

    // Gather the flat row ports into a packed array of row payloads.
    always_comb begin
        rows[0] = '{b: ha_array_0_b, t: ha_array_0_t};
        rows[1] = '{b: ha_array_1_b, t: ha_array_1_t};
        rows[2] = '{b: ha_array_2_b, t: ha_array_2_t};
        rows[3] = '{b: ha_array_3_b, t: ha_array_3_t};
    end

    // Stage-1 datapath: decode rows and pair them up.
    always_comb begin
        for (int k = 0; k < int'(ROWS); k++) begin
            row_val[k] = row_decode(rows[k]);
        end
        s01_d = S1_W'(row_val[0]) + (S1_W'(row_val[1]) << 2);
        s23_d = S1_W'(row_val[2]) + (S1_W'(row_val[3]) << 2);
    end

    // Stage-2 datapath: final reduction and overflow handling.
    always_comb begin
        raw_c     = RAW_W'(s01) + (RAW_W'(s23) << 4);
        product_d = (SAT && raw_c[RAW_W-1]) ? {PROD_W{1'b1}} : raw_c[PROD_W-1:0];
    end

    // Handshake control: a stage loads when empty or when its content leaves.
    always_comb begin
        in_ready = !s1_v || !out_valid || out_ready;
        in_hs    = in_valid && in_ready;
        s2_load  = s1_v && (!out_valid || out_ready);

        s1_v_d = s1_v;
        s2_v_d = out_valid;
        if (in_hs) begin
            s1_v_d = 1'b1;
        end else if (s2_load) begin
            s1_v_d = 1'b0;
        end
        if (s2_load) begin
            s2_v_d = 1'b1;
        end else if (out_ready) begin
            s2_v_d = 1'b0;
        end
    end

    // Pipeline registers; payloads only move on their stage's load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            s01       <= '0;
            s23       <= '0;
            out_valid <= 1'b0;
            product   <= '0;
            ovf       <= 1'b0;
        end else begin
            s1_v      <= s1_v_d;
            out_valid <= s2_v_d;
            if (in_hs) begin
                s01 <= s01_d;
                s23 <= s23_d;
            end
            if (s2_load) begin
                product <= product_d;
                ovf     <= raw_c[RAW_W-1];
            end
        end
    end

`ifdef HA_REDUCE_ACC_EN
    logic out_hs;

    always_comb begin
        out_hs = out_valid && out_ready;
    end

    // Running sum of delivered products; clear wins but keeps a coincident beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_out <= '0;
        end else if (acc_clr) begin
            acc_out <= out_hs ? ACC_W'(product) : '0;
        end else if (out_hs) begin
            acc_out <= acc_out + ACC_W'(product);
        end
    end
`endif

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
module tb_unsigned_mul_8x8_ha_array_reducer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             in_valid;
    logic             out_ready;
    logic [3:0][6:0]  b;
    logic [3:0][8:0]  t;

    logic             in_ready_s, in_ready_w;
    logic             out_valid_s, out_valid_w;
    logic [15:0]      product_s, product_w;
    logic             ovf_s, ovf_w;
`ifdef HA_REDUCE_ACC_EN
    logic             acc_clr;
    logic [31:0]      acc_out_s, acc_out_w;
    logic [31:0]      acc_model;
`endif

    unsigned_mul_8x8_ha_array_reducer u_dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .ha_array_0_b(b[0]), .ha_array_0_t(t[0]),
        .ha_array_1_b(b[1]), .ha_array_1_t(t[1]),
        .ha_array_2_b(b[2]), .ha_array_2_t(t[2]),
        .ha_array_3_b(b[3]), .ha_array_3_t(t[3]),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .product(product_s), .ovf(ovf_s)
`ifdef HA_REDUCE_ACC_EN
        , .acc_clr(acc_clr), .acc_out(acc_out_s)
`endif
    );

    unsigned_mul_8x8_ha_array_reducer #(.SAT(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .ha_array_0_b(b[0]), .ha_array_0_t(t[0]),
        .ha_array_1_b(b[1]), .ha_array_1_t(t[1]),
        .ha_array_2_b(b[2]), .ha_array_2_t(t[2]),
        .ha_array_3_b(b[3]), .ha_array_3_t(t[3]),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .product(product_w), .ovf(ovf_w)
`ifdef HA_REDUCE_ACC_EN
        , .acc_clr(acc_clr), .acc_out(acc_out_w)
`endif
    );

    typedef struct {
        logic [15:0] p_sat;
        logic [15:0] p_wrap;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    bit   rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: weighted bit sums in plain integer arithmetic.
    function automatic exp_t model(input logic [3:0][6:0] bb, input logic [3:0][8:0] tt);
        int unsigned r [4];
        int unsigned raw;
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            r[k] = 32'(tt[k]) + 4 * 32'(bb[k][5:0]) + 256 * 32'(bb[k][6]);
        end
        raw      = r[0] + 4 * r[1] + 16 * r[2] + 64 * r[3];
        e.ovf    = (raw > 65535);
        e.p_wrap = 16'(raw % 65536);
        e.p_sat  = e.ovf ? 16'hFFFF : e.p_wrap;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_exp(input logic [3:0][6:0] bb, input logic [3:0][8:0] tt, input exp_t e);
        int  n    = 0;
        bit  done = 1'b0;
        b        = bb;
        t        = tt;
        in_valid = 1'b1;
        while (!done) begin
            #1;
            if (in_ready_s) begin
                q.push_back(e);
                done = 1'b1;
            end else if (n >= 200) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", n);
                done = 1'b1;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0][6:0] bb, input logic [3:0][8:0] tt);
        send_exp(bb, tt, model(bb, tt));
    endtask

    task automatic rand_rows(output logic [3:0][6:0] bb, output logic [3:0][8:0] tt);
        int mode = $urandom_range(0, 7);
        for (int k = 0; k < 4; k++) begin
            bb[k] = (mode == 0) ? 7'h7F : (mode == 1) ? 7'h00 : 7'($urandom);
            tt[k] = (mode == 0) ? 9'h1FF : 9'($urandom);
        end
    endtask

    // Monitor: a beat is consumed at the next rising edge when valid & ready.
    always @(negedge clk) begin
`ifdef HA_REDUCE_ACC_EN
        if (!rst_n) acc_model = '0;
        else check("acc_out", acc_out_s, acc_model);
`endif
        if (rst_n && out_valid_s && out_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got product %0d expected no beat", product_s);
            end else begin
                mon_e = q.pop_front();
                check("product_sat", 32'(product_s), 32'(mon_e.p_sat));
                check("product_wrap", 32'(product_w), 32'(mon_e.p_wrap));
                check("ovf_sat", 32'(ovf_s), 32'(mon_e.ovf));
                check("ovf_wrap", 32'(ovf_w), 32'(mon_e.ovf));
                check("valid_wrap", 32'(out_valid_w), 32'd1);
`ifdef HA_REDUCE_ACC_EN
                if (acc_clr) acc_model = 32'(mon_e.p_sat);
                else         acc_model = acc_model + 32'(mon_e.p_sat);
`endif
            end
        end else begin
`ifdef HA_REDUCE_ACC_EN
            if (rst_n && acc_clr) acc_model = '0;
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][6:0] bb;
        logic [3:0][8:0] tt;
        exp_t e1, e3;
        int n;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        b         = '0;
        t         = '0;
`ifdef HA_REDUCE_ACC_EN
        acc_clr   = 1'b0;
        acc_model = '0;
`endif
        repeat (2) @(posedge clk);
        #3;
        check("rst_out_valid", 32'(out_valid_s), 32'd0);
        check("rst_product", 32'(product_s), 32'd0);
        check("rst_ovf", 32'(ovf_s), 32'd0);
        check("rst_in_ready", 32'(in_ready_s), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Unit rows: product 85 with two-edge latency.
        bb = '0;
        tt = {4{9'h001}};
        send_exp(bb, tt, '{16'd85, 16'd85, 1'b0});
        #1;
        check("latency_edge1", 32'(out_valid_s), 32'd0);
        tick();
        #1;
        check("latency_edge2", 32'(out_valid_s), 32'd1);
        repeat (2) tick();

        // Single-bit weights and the overflow corner, back to back.
        bb = '0; bb[3] = 7'h40; tt = '0;
        send_exp(bb, tt, '{16'd16384, 16'd16384, 1'b0});
        bb = '0; bb[0] = 7'h01; tt = '0;
        send_exp(bb, tt, '{16'd4, 16'd4, 1'b0});
        bb = {4{7'h7F}}; tt = {4{9'h1FF}};
        send_exp(bb, tt, '{16'hFFFF, 16'd21079, 1'b1});
        repeat (4) tick();
        check("drain_directed", 32'(q.size()), 32'd0);

        // Stall: two accepts fill the pipe, output holds, nothing lost.
        out_ready = 1'b0;
        rand_rows(bb, tt);
        e1 = model(bb, tt);
        b = bb; t = tt; in_valid = 1'b1;
        #1;
        check("stall_accept1", 32'(in_ready_s), 32'd1);
        q.push_back(e1);
        tick();
        rand_rows(bb, tt);
        b = bb; t = tt;
        #1;
        check("stall_accept2", 32'(in_ready_s), 32'd1);
        q.push_back(model(bb, tt));
        tick();
        rand_rows(bb, tt);
        e3 = model(bb, tt);
        b = bb; t = tt;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", 32'(in_ready_s), 32'd0);
            check("stall_out_valid", 32'(out_valid_s), 32'd1);
            check("stall_product_hold", 32'(product_s), 32'(e1.p_sat));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("stall_release_ready", 32'(in_ready_s), 32'd1);
        q.push_back(e3);
        tick();
        in_valid = 1'b0;
        rand_rows(bb, tt);
        send(bb, tt);
        repeat (4) tick();
        check("drain_stall", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rand_rows(bb, tt);
            if ($urandom_range(0, 4) == 0) tick();
            send(bb, tt);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        repeat (2) tick();
        check("drain_random", 32'(q.size()), 32'd0);

        // Reset with two beats in flight discards them.
        out_ready = 1'b0;
        rand_rows(bb, tt);
        send(bb, tt);
        rand_rows(bb, tt);
        send(bb, tt);
        rst_n = 1'b0;
        #1;
        check("rst_flush_valid", 32'(out_valid_s), 32'd0);
        check("rst_flush_valid_wrap", 32'(out_valid_w), 32'd0);
        q.delete();
        tick();
        tick();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready_s), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            check("rst_no_stale", 32'(out_valid_s), 32'd0);
        end

`ifdef HA_REDUCE_ACC_EN
        // Accumulator: idle clear, three deliveries of 85, clear with a beat.
        acc_clr = 1'b1;
        tick();
        acc_clr = 1'b0;
        #1;
        check("acc_clr_idle", acc_out_s, 32'd0);
        bb = '0;
        tt = {4{9'h001}};
        for (int i = 0; i < 3; i++) send_exp(bb, tt, '{16'd85, 16'd85, 1'b0});
        repeat (4) tick();
        #1;
        check("acc_sum_255", acc_out_s, 32'd255);
        acc_clr = 1'b1;
        send_exp(bb, tt, '{16'd85, 16'd85, 1'b0});
        tick();
        tick();
        acc_clr = 1'b0;
        #1;
        check("acc_clr_with_beat", acc_out_s, 32'd85);
        repeat (2) tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
